// File: rtl/xnor_pulse_sched.sv
// Sequences one XNOR operation into a toggle-encoded RSFQ XNOR cell and
// checks the cell's q toggle line against the expected result.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | in_ready high, waiting for an operand pair
// SEND_A   | a_tgl flips on the edge leaving this state
// GAP_AB   | spacing between the a pulse and the b pulse
// SEND_B   | b_tgl flips on the edge leaving this state
// GAP_DC   | spacing between the last data pulse and the clock pulse
// SEND_CLK | sclk_tgl flips on the edge leaving this state
// WAIT_Q   | observe synchronized q edges for Q_WAIT ticks
// REPORT   | result strobe registered on the edge leaving this state
// COOL     | cooldown before the next operand pair
module xnor_pulse_sched #(
    parameter int CW      = 8,
    parameter int GAP_AB  = 10,
    parameter int GAP_DC  = 8,
    parameter int Q_WAIT  = 16,
    parameter int GAP_CLK = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_a,
    input  logic in_b,
    output logic a_tgl,
    output logic b_tgl,
    output logic sclk_tgl,
    input  logic q_tgl,
    output logic res_valid,
    output logic res_q,
    output logic res_err,
    output logic stray
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEND_A,
        S_GAP_AB,
        S_SEND_B,
        S_GAP_DC,
        S_SEND_CLK,
        S_WAIT_Q,
        S_REPORT,
        S_COOL
    } state_t;

    // A gap of zero cannot be honoured, so it is clamped to one tick.
    localparam int GAB_E = (GAP_AB  < 1) ? 1 : GAP_AB;
    localparam int GDC_E = (GAP_DC  < 1) ? 1 : GAP_DC;
    localparam int QW_E  = (Q_WAIT  < 1) ? 1 : Q_WAIT;
    localparam int GCL_E = (GAP_CLK < 1) ? 1 : GAP_CLK;

    localparam logic [CW-1:0] GAB_M1 = CW'(GAB_E - 1);
    localparam logic [CW-1:0] GDC_M1 = CW'(GDC_E - 1);
    localparam logic [CW-1:0] QW_M1  = CW'(QW_E - 1);
    localparam logic [CW-1:0] GCL_M1 = CW'(GCL_E - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    qcnt_q, qcnt_d;
    logic          op_a_q, op_a_d;
    logic          op_b_q, op_b_d;
    logic          res_valid_q, res_valid_d;
    logic          res_q_q, res_q_d;
    logic          res_err_q, res_err_d;
    logic          stray_q, stray_d;
    logic          a_tgl_q, a_tgl_d;
    logic          b_tgl_q, b_tgl_d;
    logic          sclk_tgl_q, sclk_tgl_d;
    logic          q_s1_q, q_s2_q, q_s3_q;
    logic          q_edge;
    logic          accept;
    logic          one_edge;
    logic          exp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_a) begin
                        state_d = S_SEND_A;
                    end else if (in_b) begin
                        state_d = S_SEND_B;
                    end else begin
                        state_d = S_SEND_CLK;
                    end
                end
            end
            S_SEND_A: begin
                if (op_b_q) begin
                    cnt_d   = GAB_M1;
                    state_d = (GAB_M1 == '0) ? S_SEND_B : S_GAP_AB;
                end else begin
                    cnt_d   = GDC_M1;
                    state_d = (GDC_M1 == '0) ? S_SEND_CLK : S_GAP_DC;
                end
            end
            S_GAP_AB: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) state_d = S_SEND_B;
            end
            S_SEND_B: begin
                cnt_d   = GDC_M1;
                state_d = (GDC_M1 == '0) ? S_SEND_CLK : S_GAP_DC;
            end
            S_GAP_DC: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) state_d = S_SEND_CLK;
            end
            S_SEND_CLK: begin
                cnt_d   = QW_M1;
                state_d = S_WAIT_Q;
            end
            S_WAIT_Q: begin
                if (cnt_q == '0) state_d = S_REPORT;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_REPORT: begin
                cnt_d   = GCL_M1;
                state_d = S_COOL;
            end
            S_COOL: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        in_ready    = (state_q == S_IDLE);
        accept      = in_ready & in_valid;
        q_edge      = q_s2_q ^ q_s3_q;
        one_edge    = (qcnt_q == 2'd1);
        exp_q       = ~(op_a_q ^ op_b_q);

        a_tgl_d     = a_tgl_q    ^ (state_q == S_SEND_A);
        b_tgl_d     = b_tgl_q    ^ (state_q == S_SEND_B);
        sclk_tgl_d  = sclk_tgl_q ^ (state_q == S_SEND_CLK);

        op_a_d      = accept ? in_a : op_a_q;
        op_b_d      = accept ? in_b : op_b_q;

        qcnt_d      = qcnt_q;
        if (state_q == S_SEND_CLK) begin
            qcnt_d = 2'd0;
        end else if ((state_q == S_WAIT_Q) && q_edge && (qcnt_q != 2'd3)) begin
            qcnt_d = qcnt_q + 2'd1;
        end

        res_valid_d = (state_q == S_REPORT);
        res_q_d     = res_q_q;
        res_err_d   = res_err_q;
        if (state_q == S_REPORT) begin
            res_q_d   = one_edge;
            res_err_d = (qcnt_q >= 2'd2) || (one_edge != exp_q);
        end

        stray_d     = stray_q | (q_edge & (state_q != S_WAIT_Q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            qcnt_q      <= 2'd0;
            op_a_q      <= 1'b0;
            op_b_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_q_q     <= 1'b0;
            res_err_q   <= 1'b0;
            stray_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            qcnt_q      <= qcnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            res_valid_q <= res_valid_d;
            res_q_q     <= res_q_d;
            res_err_q   <= res_err_d;
            stray_q     <= stray_d;
        end
    end

    // Toggle lines are outside reset: clearing one would look like a pulse to the cell.
    always_ff @(posedge clk) begin
        a_tgl_q    <= a_tgl_d;
        b_tgl_q    <= b_tgl_d;
        sclk_tgl_q <= sclk_tgl_d;
    end

    always_ff @(posedge clk) begin
        q_s1_q <= q_tgl;
        q_s2_q <= q_s1_q;
        q_s3_q <= q_s2_q;
    end

    assign a_tgl     = a_tgl_q;
    assign b_tgl     = b_tgl_q;
    assign sclk_tgl  = sclk_tgl_q;
    assign res_valid = res_valid_q;
    assign res_q     = res_q_q;
    assign res_err   = res_err_q;
    assign stray     = stray_q;

endmodule

// File: tb/tb_xnor_pulse_sched.sv
// Directed bench for xnor_pulse_sched with short gaps; edge numbers are
// counted from the accepting edge E0.
module tb_xnor_pulse_sched;

    logic clk, rst;
    logic in_valid, in_ready, in_a, in_b;
    logic a_tgl, b_tgl, sclk_tgl, q_tgl;
    logic res_valid, res_q, res_err, stray;

    int n_checks = 0;
    int n_fail   = 0;

    xnor_pulse_sched #(
        .CW(8), .GAP_AB(3), .GAP_DC(2), .Q_WAIT(6), .GAP_CLK(4)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .a_tgl(a_tgl), .b_tgl(b_tgl), .sclk_tgl(sclk_tgl), .q_tgl(q_tgl),
        .res_valid(res_valid), .res_q(res_q), .res_err(res_err), .stray(stray)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one operation and records at which edge each event happened.
    // npulse: q toggles produced by the cell model (1: at Tclk+2, 2: at Tclk+1 and +2).
    task automatic run_op(input logic a, input logic b, input int npulse,
                          input bit hold, input bit poke,
                          output int ta, output int tb, output int tc,
                          output int tres, output int tready,
                          output int na, output int nb, output int nres,
                          output logic rq, output logic re);
        logic pa, pb, pc;
        int guard;
        ta = -1; tb = -1; tc = -1; tres = -1; tready = -1;
        na = 0; nb = 0; nres = 0; rq = 1'bx; re = 1'bx;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b1; in_a = a; in_b = b;
        pa = a_tgl; pb = b_tgl; pc = sclk_tgl;
        @(posedge clk); #1;
        if (!hold) in_valid = 1'b0;
        for (int k = 1; k <= 60 && tready < 0; k++) begin
            @(posedge clk); #1;
            if (a_tgl !== pa)    begin na++; if (ta < 0) ta = k; pa = a_tgl; end
            if (b_tgl !== pb)    begin nb++; if (tb < 0) tb = k; pb = b_tgl; end
            if (sclk_tgl !== pc) begin if (tc < 0) tc = k; pc = sclk_tgl; end
            if (res_valid === 1'b1) begin nres++; tres = k; rq = res_q; re = res_err; end
            if (in_ready === 1'b1 && tready < 0) tready = k;
            if (tc > 0 && ((npulse >= 1 && k == tc + 2) || (npulse >= 2 && k == tc + 1)))
                q_tgl = ~q_tgl;
            if (poke) begin
                if (k == 5) begin in_valid = 1'b1; in_a = ~a; in_b = ~b; end
                else if (k == 6) in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_a = 1'b0; in_b = 1'b0; q_tgl = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        n_checks++; if ({res_valid, res_q, res_err, stray} !== 4'b0000)
            begin n_fail++; $display("FAIL rst_outputs got %b want 0000", {res_valid, res_q, res_err, stray}); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if ({in_ready, res_valid, stray} !== 3'b100)
            begin n_fail++; $display("FAIL post_rst got %b want 100", {in_ready, res_valid, stray}); end
    endtask

    task automatic test_a1_b1;
        int ta, tb, tc, tres, tready, na, nb, nres; logic rq, re;
        run_op(1'b1, 1'b1, 1, 1'b0, 1'b0, ta, tb, tc, tres, tready, na, nb, nres, rq, re);
        n_checks++; if (ta !== 1)  begin n_fail++; $display("FAIL t11_a_edge got %0d want 1", ta); end
        n_checks++; if (tb !== 4)  begin n_fail++; $display("FAIL t11_b_edge got %0d want 4", tb); end
        n_checks++; if (tc !== 6)  begin n_fail++; $display("FAIL t11_clk_edge got %0d want 6", tc); end
        n_checks++; if (tres !== 13) begin n_fail++; $display("FAIL t11_res_edge got %0d want 13", tres); end
        n_checks++; if (tready !== 17) begin n_fail++; $display("FAIL t11_ready_edge got %0d want 17", tready); end
        n_checks++; if ({na, nb, nres} !== {32'd1, 32'd1, 32'd1})
            begin n_fail++; $display("FAIL t11_counts got a=%0d b=%0d res=%0d want 1 1 1", na, nb, nres); end
        n_checks++; if ({rq, re} !== 2'b10) begin n_fail++; $display("FAIL t11_result got %b want 10", {rq, re}); end
        n_checks++; if ({res_q, res_err} !== 2'b10) begin n_fail++; $display("FAIL t11_hold got %b want 10", {res_q, res_err}); end
    endtask

    // Also pokes in_valid with inverted operands mid-operation, which must be ignored.
    task automatic test_a1_b0;
        int ta, tb, tc, tres, tready, na, nb, nres; logic rq, re;
        run_op(1'b1, 1'b0, 0, 1'b0, 1'b1, ta, tb, tc, tres, tready, na, nb, nres, rq, re);
        n_checks++; if (ta !== 1)  begin n_fail++; $display("FAIL t10_a_edge got %0d want 1", ta); end
        n_checks++; if (nb !== 0)  begin n_fail++; $display("FAIL t10_b_flips got %0d want 0", nb); end
        n_checks++; if (tc !== 3)  begin n_fail++; $display("FAIL t10_clk_edge got %0d want 3", tc); end
        n_checks++; if (tres !== 10) begin n_fail++; $display("FAIL t10_res_edge got %0d want 10", tres); end
        n_checks++; if (tready !== 14) begin n_fail++; $display("FAIL t10_ready_edge got %0d want 14", tready); end
        n_checks++; if ({rq, re} !== 2'b00) begin n_fail++; $display("FAIL t10_result got %b want 00", {rq, re}); end
    endtask

    task automatic test_back_to_back;
        int ta, tb, tc, tres, tready, na, nb, nres; logic rq, re;
        logic pc;
        int tr2;
        run_op(1'b0, 1'b0, 1, 1'b1, 1'b0, ta, tb, tc, tres, tready, na, nb, nres, rq, re);
        n_checks++; if ({na, nb} !== {32'd0, 32'd0}) begin n_fail++; $display("FAIL t00_data_flips got a=%0d b=%0d want 0 0", na, nb); end
        n_checks++; if (tc !== 1)  begin n_fail++; $display("FAIL t00_clk_edge got %0d want 1", tc); end
        n_checks++; if (tres !== 8) begin n_fail++; $display("FAIL t00_res_edge got %0d want 8", tres); end
        n_checks++; if (tready !== 12) begin n_fail++; $display("FAIL t00_ready_edge got %0d want 12", tready); end
        n_checks++; if ({rq, re} !== 2'b10) begin n_fail++; $display("FAIL t00_result got %b want 10", {rq, re}); end
        pc = sclk_tgl;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept_e13 got ready=%b want 0", in_ready); end
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (sclk_tgl === pc) begin n_fail++; $display("FAIL b2b_clk_e14 got %b want %b", sclk_tgl, ~pc); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        q_tgl = ~q_tgl;
        tr2 = -1;
        for (int k = 17; k <= 40 && tr2 < 0; k++) begin
            @(posedge clk); #1;
            if (res_valid === 1'b1) begin tr2 = k; rq = res_q; re = res_err; end
        end
        n_checks++; if (tr2 !== 21) begin n_fail++; $display("FAIL b2b_res_edge got %0d want 21", tr2); end
        n_checks++; if ({rq, re} !== 2'b10) begin n_fail++; $display("FAIL b2b_result got %b want 10", {rq, re}); end
    endtask

    task automatic test_faulty_q;
        int ta, tb, tc, tres, tready, na, nb, nres; logic rq, re;
        run_op(1'b0, 1'b1, 2, 1'b0, 1'b0, ta, tb, tc, tres, tready, na, nb, nres, rq, re);
        n_checks++; if (tb !== 1)  begin n_fail++; $display("FAIL t01_b_edge got %0d want 1", tb); end
        n_checks++; if (tc !== 3)  begin n_fail++; $display("FAIL t01_clk_edge got %0d want 3", tc); end
        n_checks++; if (tres !== 10) begin n_fail++; $display("FAIL t01_res_edge got %0d want 10", tres); end
        n_checks++; if ({rq, re} !== 2'b01) begin n_fail++; $display("FAIL t01_double_q got %b want 01", {rq, re}); end
        run_op(1'b0, 1'b1, 1, 1'b0, 1'b0, ta, tb, tc, tres, tready, na, nb, nres, rq, re);
        n_checks++; if ({rq, re} !== 2'b11) begin n_fail++; $display("FAIL t01_single_q got %b want 11", {rq, re}); end
        n_checks++; if (stray !== 1'b0) begin n_fail++; $display("FAIL t01_no_stray got %b want 0", stray); end
    endtask

    task automatic test_stray;
        int ta, tb, tc, tres, tready, na, nb, nres; logic rq, re;
        int nrv;
        nrv = 0;
        q_tgl = ~q_tgl;
        repeat (6) begin
            @(posedge clk); #1;
            if (res_valid === 1'b1) nrv++;
        end
        n_checks++; if (stray !== 1'b1) begin n_fail++; $display("FAIL stray_set got %b want 1", stray); end
        n_checks++; if (nrv !== 0) begin n_fail++; $display("FAIL stray_no_res got %0d want 0", nrv); end
        run_op(1'b1, 1'b0, 0, 1'b0, 1'b0, ta, tb, tc, tres, tready, na, nb, nres, rq, re);
        n_checks++; if (stray !== 1'b1) begin n_fail++; $display("FAIL stray_sticky got %b want 1", stray); end
        n_checks++; if (nres !== 1) begin n_fail++; $display("FAIL stray_op_res got %0d want 1", nres); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (stray !== 1'b0) begin n_fail++; $display("FAIL stray_cleared got %b want 0", stray); end
    endtask

    task automatic test_reset_mid_op;
        int ta, tb, tc, tres, tready, na, nb, nres; logic rq, re;
        logic a0, la, lb, lc;
        int nrv;
        nrv = 0;
        a0 = a_tgl;
        in_valid = 1'b1; in_a = 1'b1; in_b = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        la = a_tgl; lb = b_tgl; lc = sclk_tgl;
        n_checks++; if (la === a0) begin n_fail++; $display("FAIL rmid_a_flipped got %b want %b", la, ~a0); end
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if ({a_tgl, b_tgl, sclk_tgl} !== {la, lb, lc})
            begin n_fail++; $display("FAIL rmid_tgl_hold got %b want %b", {a_tgl, b_tgl, sclk_tgl}, {la, lb, lc}); end
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got %b want 1", in_ready); end
        repeat (12) begin
            @(posedge clk); #1;
            if (res_valid === 1'b1) nrv++;
        end
        n_checks++; if (nrv !== 0) begin n_fail++; $display("FAIL rmid_no_res got %0d want 0", nrv); end
        run_op(1'b1, 1'b1, 1, 1'b0, 1'b0, ta, tb, tc, tres, tready, na, nb, nres, rq, re);
        n_checks++; if ({ta, tb, tc} !== {32'd1, 32'd4, 32'd6})
            begin n_fail++; $display("FAIL rmid_pulses got %0d %0d %0d want 1 4 6", ta, tb, tc); end
        n_checks++; if ({tres, tready} !== {32'd13, 32'd17})
            begin n_fail++; $display("FAIL rmid_res got %0d %0d want 13 17", tres, tready); end
        n_checks++; if ({rq, re} !== 2'b10) begin n_fail++; $display("FAIL rmid_result got %b want 10", {rq, re}); end
    endtask

    initial begin
        test_reset();
        test_a1_b1();
        test_a1_b0();
        test_back_to_back();
        test_faulty_q();
        test_stray();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
